// File: rtl/lorenz_stream_pkg.sv
// Shared constants, state encoding and helpers for the
// lorenz_rk4 UART streaming path.
package lorenz_stream_pkg;

   localparam int         Q_W         = 32;
   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 14;
   localparam int         DATA_BYTES  = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_e;

   // XOR of all data bytes of a captured x/y/z triple
   function automatic logic [7:0] xor_bytes(
      input logic [8*DATA_BYTES-1:0] w
   );
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         acc = acc ^ w[8*i +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/lorenz_uart_streamer_tx_byte.sv
// UART 8N1 byte transmitter; a new start accepted during the last
// stop-bit cycle chains bytes with no idle gap.
module uart_tx_byte
   import lorenz_stream_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready,
   output logic       done
);

   localparam int            TW   = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end = (timer_q == TMAX);
   assign done    = (state_q == ST_STOP) && bit_end;
   assign ready   = (state_q == ST_IDLE) || done;
   assign tx      = tx_q;

   // state, timer, shifter and the registered line
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // bit sequencing; a start request overrides the stop-bit exit
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if ((state_q == ST_IDLE) || bit_end) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
      case (state_q)
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: ;
      endcase
      if (start && ready) begin
         state_d = ST_START;
         shift_d = data;
         bit_d   = '0;
         timer_d = '0;
         tx_d    = 1'b0;
      end
   end

endmodule

// File: rtl/lorenz_uart_streamer.sv
// Decimates the Lorenz x/y/z stream and ships selected samples as
// 14-byte checksummed UART frames.
module lorenz_uart_streamer
   import lorenz_stream_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DECIM        = 1024,
   parameter int DROP_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [Q_W-1:0]    x,
   input  logic [Q_W-1:0]    y,
   input  logic [Q_W-1:0]    z,
   output logic              tx,
   output logic              busy,
   output logic              frame_done,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int            DW   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DECIM - 1);
   localparam logic [3:0]    LAST = 4'(FRAME_BYTES - 1);
   localparam logic [3:0]    NDAT = 4'(DATA_BYTES);

   logic [DW-1:0]     decim_q;
   logic [3*Q_W-1:0]  shadow_q;
   logic [7:0]        csum_q;
   logic [3:0]        byte_q;
   logic              active_q;
   logic              done_q;
   logic [DROP_W-1:0] drop_q;

   logic       take, sel, capture, advance, last_byte;
   logic       u_start, u_ready, u_done, u_tx;
   logic [3:0] k;
   logic [7:0] nbyte, u_data;

   assign take      = en && sample_valid;
   assign sel       = take && (decim_q == DMAX);
   assign capture   = sel && !active_q && u_ready;
   assign last_byte = (byte_q == LAST);
   assign advance   = active_q && u_done;
   assign u_start   = capture || (advance && !last_byte);

   // byte following byte_q: data bytes MSB-first, then checksum
   always_comb begin
      k     = (NDAT - 4'd1) - byte_q;
      nbyte = csum_q;
      if (byte_q < NDAT) begin
         nbyte = shadow_q[{k, 3'b000} +: 8];
      end
      u_data = capture ? SYNC_BYTE : nbyte;
   end

   // decimation, capture, byte sequencing and drop accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         decim_q  <= '0;
         shadow_q <= '0;
         csum_q   <= '0;
         byte_q   <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (take) begin
            decim_q <= (decim_q == DMAX) ? '0 : decim_q + 1'b1;
         end
         if (capture) begin
            shadow_q <= {x, y, z};
            csum_q   <= xor_bytes({x, y, z});
            byte_q   <= '0;
            active_q <= 1'b1;
         end
         if (sel && active_q && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
         end
         if (advance) begin
            if (last_byte) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end else begin
               byte_q <= byte_q + 1'b1;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk  (clk),
      .rst  (rst),
      .start(u_start),
      .data (u_data),
      .tx   (u_tx),
      .ready(u_ready),
      .done (u_done)
   );

   assign tx         = u_tx;
   assign busy       = active_q;
   assign frame_done = done_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_lorenz_uart_streamer.sv
// Bench for lorenz_uart_streamer: frame-level reference model plus
// directed scenarios and a randomized soak.
module tb_lorenz_uart_streamer;

   localparam int CPB    = 4;
   localparam int DECIM  = 4;
   localparam int DROP_W = 4;
   localparam int NBITS  = 140;
   localparam int FLEN   = NBITS * CPB;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              sample_valid = 1'b0;
   logic [31:0]       x = '0;
   logic [31:0]       y = '0;
   logic [31:0]       z = '0;
   logic              tx, busy, frame_done;
   logic [DROP_W-1:0] drop_cnt;

   always #5 clk = ~clk;

   lorenz_uart_streamer #(
      .CLKS_PER_BIT(CPB),
      .DECIM       (DECIM),
      .DROP_W      (DROP_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sample_valid(sample_valid),
      .x           (x),
      .y           (y),
      .z           (z),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done),
      .drop_cnt    (drop_cnt)
   );

   int checks = 0;
   int errors = 0;
   int frames = 0;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // reference model: position within the 140-bit frame image
   int         m_pos = -1;
   int         m_decim = 0;
   int         m_drop = 0;
   bit         m_fd = 0;
   bit         m_bits[NBITS];
   bit         chk_on = 0;
   bit         busy_pre, s_sel;
   logic [7:0] fr[14];

   always @(posedge clk) begin
      if (rst) begin
         m_pos   = -1;
         m_decim = 0;
         m_drop  = 0;
         m_fd    = 0;
         chk_on  = 1;
      end else begin
         busy_pre = (m_pos >= 0);
         s_sel    = en && sample_valid && (m_decim == DECIM - 1);
         if (en && sample_valid) m_decim = (m_decim + 1) % DECIM;
         m_fd = 0;
         if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FLEN) begin
               m_pos = -1;
               m_fd  = 1;
            end
         end
         if (s_sel) begin
            if (busy_pre) begin
               if (m_drop < 2**DROP_W - 1) m_drop++;
            end else begin
               fr[0]  = 8'hA5;
               fr[13] = 8'h00;
               for (int i = 0; i < 4; i++) begin
                  fr[1+i] = x[31-8*i -: 8];
                  fr[5+i] = y[31-8*i -: 8];
                  fr[9+i] = z[31-8*i -: 8];
               end
               for (int i = 1; i <= 12; i++) fr[13] = fr[13] ^ fr[i];
               for (int b = 0; b < 14; b++) begin
                  m_bits[10*b] = 1'b0;
                  for (int i = 0; i < 8; i++) m_bits[10*b+1+i] = fr[b][i];
                  m_bits[10*b+9] = 1'b1;
               end
               m_pos = 0;
            end
         end
      end
   end

   always @(posedge clk) if (frame_done === 1'b1) frames++;

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("tx", tx, (m_pos < 0) ? 1'b1 : m_bits[m_pos / CPB]);
         chk("busy", busy, m_pos >= 0);
         chk("frame_done", frame_done, m_fd);
         chk("drop_cnt", drop_cnt, m_drop);
      end
   end

   logic [7:0] rxb[14];
   logic [7:0] t1_exp[14] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00,
                              8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                              8'h18, 8'h00, 8'h00, 8'h19};

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic valids(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         if (rnd) begin
            x = $urandom;
            y = $urandom;
            z = $urandom;
         end
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle", busy, 1'b0);
   endtask

   // mid-bit sampling of tx, starting at the first start-bit cycle
   task automatic rx(input int nb);
      int bi;
      for (int c = 0; c < nb * 10 * CPB; c++) begin
         if (c % CPB == CPB / 2) begin
            bi = c / CPB;
            if (bi % 10 >= 1 && bi % 10 <= 8) rxb[bi/10][bi%10-1] = tx;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int f0, d0, k;
      cyc(2);
      rst = 1'b0;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_drop", drop_cnt, 0);

      // single frame with known payload
      en = 1'b1;
      x = 32'h0001_0000;
      y = 32'hFFFF_0000;
      z = 32'h0018_0000;
      valids(4, 1'b0);
      chk("t1_latency", tx, 1'b0);
      x = $urandom;
      y = $urandom;
      z = $urandom;
      rx(14);
      chk("t1_done_560", frame_done, 1'b1);
      for (int i = 0; i < 14; i++) chk("t1_byte", rxb[i], t1_exp[i]);
      cyc(3);

      // decimation and a single drop
      pulse_rst();
      f0 = frames;
      valids(8, 1'b1);
      chk("t2_drop", drop_cnt, 1);
      wait_idle(700);
      cyc(20);
      chk("t2_frames", frames - f0, 1);

      // reset mid-frame, then a clean frame
      pulse_rst();
      valids(4, 1'b1);
      cyc(50);
      valids(4, 1'b1);
      cyc(42);
      chk("t3_predrop", drop_cnt, 1);
      pulse_rst();
      chk("t3_tx", tx, 1'b1);
      chk("t3_busy", busy, 1'b0);
      chk("t3_drop", drop_cnt, 0);
      cyc(3);
      valids(4, 1'b1);
      rx(1);
      chk("t3_sync", rxb[0], 8'hA5);
      wait_idle(700);

      // back-to-back frames
      valids(4, 1'b1);
      valids(3, 1'b1);
      d0 = int'(drop_cnt);
      k = 0;
      while (frame_done !== 1'b1 && k < 700) begin
         @(negedge clk);
         k++;
      end
      chk("t4_fd", frame_done, 1'b1);
      valids(1, 1'b1);
      chk("t4_start", tx, 1'b0);
      chk("t4_drop", drop_cnt, d0);
      wait_idle(700);

      // enable gating
      pulse_rst();
      f0 = frames;
      en = 1'b0;
      valids(50, 1'b1);
      chk("t5_idle", busy, 1'b0);
      en = 1'b1;
      valids(3, 1'b1);
      en = 1'b0;
      valids(50, 1'b1);
      en = 1'b1;
      valids(1, 1'b1);
      chk("t5_decim_held", busy, 1'b1);
      cyc(30);
      en = 1'b0;
      valids(40, 1'b1);
      wait_idle(700);
      valids(20, 1'b1);
      cyc(10);
      chk("t5_frames", frames - f0, 1);
      chk("t5_no_restart", busy, 1'b0);

      // drop counter saturation
      pulse_rst();
      en = 1'b1;
      valids(4 + 80, 1'b1);
      chk("t6_sat", drop_cnt, 15);
      valids(8, 1'b1);
      chk("t6_sat_hold", drop_cnt, 15);
      wait_idle(700);

      // randomized soak
      for (int i = 0; i < 5000; i++) begin
         en           = ($urandom_range(0, 9) != 0);
         sample_valid = ($urandom_range(0, 2) == 0);
         rst          = ($urandom_range(0, 999) == 0);
         x = $urandom;
         y = $urandom;
         z = $urandom;
         @(negedge clk);
      end
      rst = 1'b0;
      sample_valid = 1'b0;
      wait_idle(700);
      cyc(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
